// File: rtl/circuit.sv
// circuit: two-stage registered signed running accumulator, y = sum of accepted x samples.
// Define CIRCUIT_SAT_EN for a saturating accumulator; the default build wraps modulo 2^W.
module circuit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic         en_r;
  logic [W-1:0] x_r;
  logic [W-1:0] acc;
  logic [W-1:0] nxt;
`ifdef CIRCUIT_SAT_EN
  logic [W:0] sum;
  logic       ovf;
  always_comb begin
    sum = {acc[W-1], acc} + {x_r[W-1], x_r};
    ovf = (acc[W-1] == x_r[W-1]) && (sum[W-1] != acc[W-1]);
    // on overflow the operand sign tells which rail to clamp to
    nxt = !ovf ? sum[W-1:0] : acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  always_comb nxt = acc + x_r;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r <= 1'b0;
      x_r  <= '0;
      acc  <= '0;
    end else begin
      en_r <= en;
      if (en) x_r <= x;
      if (en_r) acc <= nxt;
    end
  end
  assign y = acc;
endmodule

// File: tb/tb_circuit.sv
// tb_circuit: randomized and directed scoreboard bench for circuit against a running-sum model.
module tb_circuit;
  localparam int W = 32;
  localparam longint HALF = 64'sd1 <<< (W - 1);
  localparam longint FULL = 64'sd1 <<< W;
  typedef struct {
    logic [W-1:0] v;
    string        n;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y;
  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  longint       acc_m = 0;
  longint       pval = 0;
  bit           pv = 1'b0;
  circuit #(.W(W)) dut (.clk(clk), .rst(rst), .en(en), .x(x), .y(y));
  always #5 clk = ~clk;
  function automatic longint fold(input longint s);
`ifdef CIRCUIT_SAT_EN
    return s > HALF - 1 ? HALF - 1 : s < -HALF ? -HALF : s;
`else
    longint m;
    m = ((s % FULL) + FULL) % FULL;
    return m >= HALF ? m - FULL : m;
`endif
  endfunction
  // drive one edge; expectation is the spec constant when given, else the reference model
  task automatic step(input bit r, input bit e, input longint v, input bit use_c, input longint cv, input string n);
    exp_t   it;
    logic [63:0] t;
    @(negedge clk);
    rst = r;
    en = e;
    t = v;
    x = t[W-1:0];
    @(posedge clk);
    if (r) begin
      acc_m = 0;
      pv = 1'b0;
    end else begin
      if (pv) acc_m = fold(acc_m + pval);
      pv = e;
      if (e) pval = v;
    end
    t = use_c ? cv : acc_m;
    it.v = t[W-1:0];
    it.n = n;
    q.push_back(it);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      checks++;
      if (y !== it.v) begin
        errors++;
        $display("FAIL %s y=%0d expected=%0d", it.n, $signed(y), $signed(it.v));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    step(1, 1, 5, 1, 0, "reset0");
    step(1, 1, 5, 1, 0, "reset1");
    step(0, 1, 3, 1, 0, "basic_a");
    step(0, 1, -7, 1, 3, "basic_b");
    step(0, 1, 9, 1, -4, "basic_c");
    step(0, 1, 0, 1, 5, "basic_d");
    step(0, 1, -2, 1, 5, "basic_e");
    step(0, 0, 9, 1, 3, "basic_f");
    step(0, 0, 9, 1, 3, "basic_g");
    step(1, 0, 0, 1, 0, "gap_rst");
    step(0, 1, 4, 1, 0, "gap_a");
    step(0, 1, 4, 1, 4, "gap_b");
    for (int i = 0; i < 5; i++) step(0, 0, 9, 1, 8, "gap_hold");
    step(0, 1, -1, 1, 8, "gap_c");
    step(0, 0, 0, 1, 7, "gap_d");
    step(1, 0, 0, 1, 0, "mid_rst0");
    step(0, 1, 10, 1, 0, "mid_a");
    step(0, 1, 10, 1, 10, "mid_b");
    step(0, 0, 0, 1, 20, "mid_c");
    step(1, 1, 6, 1, 0, "mid_rst1");
    step(0, 1, 2, 1, 0, "mid_d");
    step(0, 0, 0, 1, 2, "mid_e");
    step(0, 0, 0, 1, 2, "mid_f");
    step(1, 0, 0, 1, 0, "ovf_rst0");
    step(0, 1, HALF - 8, 1, 0, "ovf_a");
    step(0, 1, 10, 1, HALF - 8, "ovf_b");
`ifdef CIRCUIT_SAT_EN
    step(0, 1, -9, 1, HALF - 1, "ovf_pos");
    step(0, 0, 0, 1, HALF - 10, "ovf_back");
`else
    step(0, 1, -9, 1, HALF + 2 - FULL, "ovf_pos");
    step(0, 0, 0, 1, HALF - 7, "ovf_back");
`endif
    step(1, 0, 0, 1, 0, "ovf_rst1");
    step(0, 1, 1 - HALF, 1, 0, "neg_a");
    step(0, 1, -5, 1, 1 - HALF, "neg_b");
`ifdef CIRCUIT_SAT_EN
    step(0, 1, 3, 1, -HALF, "neg_ovf");
    step(0, 0, 0, 1, 3 - HALF, "neg_back");
`else
    step(0, 1, 3, 1, HALF - 4, "neg_ovf");
    step(0, 0, 0, 1, HALF - 1, "neg_back");
`endif
    step(1, 0, 0, 0, 0, "soak_rst");
    for (int i = 0; i < 100; i++)
      step(0, 1, longint'($urandom_range(18)) - 9, 0, 0, "soak");
    for (int i = 0; i < 20; i++)
      step(0, $urandom_range(1), longint'($urandom_range(18)) - 9, 0, 0, "soak_gap");
    step(0, 0, 0, 0, 0, "soak_drain");
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
